io_bus_arbiter: RTL and testbench
=================================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter NOS_MASTERS, default 2, SHALL set the number of bus masters sharing the slave IO bus (legal 2..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the clk cycles allowed for a slave acknowledge before abort.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m_handshake_1  input  NOS_MASTERS  per-master transfer request (4-phase strobe).
REQ-006 m_RW  input  NOS_MASTERS  per-master direction (1 = read, 0 = write).
REQ-007 m_reg_address  input  NOS_MASTERS x 8  per-master register address.
REQ-008 m_data_out  input  NOS_MASTERS x 32  per-master write data.
REQ-009 m_handshake_2  output  NOS_MASTERS  per-master completion strobe.
REQ-010 m_data_in  output  32  read data returned to the granted master.
REQ-011 m_timeout  output  NOS_MASTERS  per-master abort flag, valid while its m_handshake_2 is high.
REQ-012 s_handshake_1, s_RW  output  1 each  request and direction to slaves.
REQ-013 s_reg_address  output  8; s_data_out  output  32: address and write data to slaves.
REQ-014 s_handshake_2  input  1; s_data_in  input  32: slave acknowledge and read data.
REQ-015 grant  output  NOS_MASTERS  one-hot current owner, all-zero when idle.

Function
REQ-016 FSM states SHALL be IDLE, REQ, ACK, DONE, ABORT.
REQ-017 IDLE: at any edge with a nonzero m_handshake_1, the arbiter SHALL pick one master round-robin, starting at (last owner + 1) mod NOS_MASTERS; register grant and go to REQ.
REQ-018 Latency: s_handshake_1 SHALL be high from the edge following the one at which the request is sampled; s_handshake_1 is a registered output.
REQ-019 While grant is nonzero, s_RW, s_reg_address, s_data_out SHALL mux combinationally from the granted master; otherwise they SHALL be 0.
REQ-020 REQ: on s_handshake_2 = 1, the arbiter SHALL capture s_data_in into m_data_in, set m_handshake_2[owner] = 1, and go to ACK.
REQ-021 ACK: s_handshake_1 SHALL stay high until m_handshake_1[owner] = 0, then drop and go to DONE.
REQ-022 DONE: on s_handshake_2 = 0, the arbiter SHALL clear m_handshake_2[owner], record the owner as last owner, clear grant, and go to IDLE.
REQ-023 Timeout counter: cleared on entry to REQ; increments each cycle in REQ, saturating; when it equals TIMEOUT_CYCLES with s_handshake_2 still 0, the arbiter SHALL drop s_handshake_1 and go to ABORT.
REQ-024 ABORT: the arbiter SHALL assert m_handshake_2[owner] and m_timeout[owner], and hold m_data_in at 0; when m_handshake_1[owner] = 0 it SHALL clear both and return to IDLE as in REQ-022.
REQ-025 Requests arriving while not IDLE SHALL wait (no queueing beyond level-held m_handshake_1); a master dropping m_handshake_1 before grant is simply skipped.
REQ-026 Simultaneous requests SHALL be resolved only by the round-robin pointer; a requester SHALL wait at most NOS_MASTERS-1 transfers.
REQ-027 m_data_in SHALL hold its value until the next capture; it is meaningful to a master only while its m_handshake_2 is high.

Reset
REQ-028 On reset low, the block SHALL enter IDLE and clear all outputs (grant, m_handshake_2, m_timeout, s_handshake_1, m_data_in, muxed slave outputs) to 0, with last owner = NOS_MASTERS-1 and the timeout counter at 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer immediately; no completion strobe is issued.

Structure
REQ-030 Package types SHALL hold NOS_MASTERS and TIMEOUT_CYCLES defaults and the enum arb_state_t.
REQ-031 Round-robin selection SHALL be a sub-module rr_picker (request vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-032 Single master 0, write addr 0x05 data 0xDEADBEEF; slave acks 3 cycles later -> s_handshake_1 high 1 cycle after request; slave sees 0x05/0xDEADBEEF; full 4-phase completes; grant returns to 0.
REQ-033 Masters 0 and 1 request in the same cycle after reset -> master 0 served first, then master 1; repeated simultaneous requests alternate 0, 1, 0, 1.
REQ-034 Read by master 1, slave returns 0x12345678 -> m_data_in = 0x12345678 while m_handshake_2[1] is high; master 0 sees no m_handshake_2.
REQ-035 Slave never acks, TIMEOUT_CYCLES = 255 -> s_handshake_1 drops after 255 REQ cycles; m_handshake_2[owner] and m_timeout[owner] rise; both clear after the master drops m_handshake_1.
REQ-036 Reset asserted in the ACK state -> all outputs 0 asynchronously; the next request is granted to master 0.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and defaults for the IO bus arbiter: FSM states and the slave request payload.
package io_bus_arbiter_pkg;

  localparam int unsigned NOS_MASTERS_DEF    = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned ADDR_W             = 8;
  localparam int unsigned DATA_W             = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    DONE,
    ABORT
  } arb_state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slave_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active request at or after (last + 1) mod N.
module rr_picker #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int unsigned c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      c = (32'(last) + i) % N;
      if (!valid && req[IDX_W'(c)]) begin
        valid              = 1'b1;
        onehot[IDX_W'(c)]  = 1'b1;
        idx                = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one 4-phase slave IO bus among several masters, with ack timeout.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int unsigned NOS_MASTERS    = NOS_MASTERS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NOS_MASTERS-1:0]              m_handshake_1,
  input  logic [NOS_MASTERS-1:0]              m_RW,
  input  logic [NOS_MASTERS-1:0][ADDR_W-1:0]  m_reg_address,
  input  logic [NOS_MASTERS-1:0][DATA_W-1:0]  m_data_out,
  output logic [NOS_MASTERS-1:0]              m_handshake_2,
  output logic [DATA_W-1:0]                   m_data_in,
  output logic [NOS_MASTERS-1:0]              m_timeout,
  output logic                                s_handshake_1,
  output logic                                s_RW,
  output logic [ADDR_W-1:0]                   s_reg_address,
  output logic [DATA_W-1:0]                   s_data_out,
  input  logic                                s_handshake_2,
  input  logic [DATA_W-1:0]                   s_data_in,
  output logic [NOS_MASTERS-1:0]              grant
);

  localparam int unsigned IDX_W = $clog2(NOS_MASTERS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NOS_MASTERS - 1);
  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t             state, state_n;
  logic [NOS_MASTERS-1:0] grant_n, hs2_n, to_n;
  logic [IDX_W-1:0]       owner, owner_n, last_owner, last_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   shs1_n;
  logic [DATA_W-1:0]      din_n;

  logic [NOS_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  slave_req_t             sreq;

  rr_picker #(.N(NOS_MASTERS)) u_picker (
    .req    (m_handshake_1),
    .last   (last_owner),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      owner         <= '0;
      last_owner    <= LAST_RST;
      cnt           <= '0;
      m_handshake_2 <= '0;
      m_timeout     <= '0;
      s_handshake_1 <= 1'b0;
      m_data_in     <= '0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      owner         <= owner_n;
      last_owner    <= last_n;
      cnt           <= cnt_n;
      m_handshake_2 <= hs2_n;
      m_timeout     <= to_n;
      s_handshake_1 <= shs1_n;
      m_data_in     <= din_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    last_n  = last_owner;
    cnt_n   = cnt;
    hs2_n   = m_handshake_2;
    to_n    = m_timeout;
    shs1_n  = s_handshake_1;
    din_n   = m_data_in;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n = pick_onehot;
          owner_n = pick_idx;
          cnt_n   = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        shs1_n = 1'b1;
        if (s_handshake_2) begin
          din_n        = s_data_in;
          hs2_n[owner] = 1'b1;
          state_n      = ACK;
        end else if (cnt == TO_MAX) begin
          // Slave never answered: abandon the bus cycle and flag the owner.
          shs1_n       = 1'b0;
          hs2_n[owner] = 1'b1;
          to_n[owner]  = 1'b1;
          din_n        = '0;
          state_n      = ABORT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ACK: begin
        if (!m_handshake_1[owner]) begin
          shs1_n  = 1'b0;
          state_n = DONE;
        end
      end
      DONE: begin
        if (!s_handshake_2) begin
          hs2_n[owner] = 1'b0;
          last_n       = owner;
          grant_n      = '0;
          state_n      = IDLE;
        end
      end
      ABORT: begin
        if (!m_handshake_1[owner]) begin
          hs2_n[owner] = 1'b0;
          to_n[owner]  = 1'b0;
          last_n       = owner;
          grant_n      = '0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Slave-side address/data follow the owner directly so the slave sees them with s_handshake_1.
  always_comb begin
    sreq = '0;
    if (|grant) begin
      sreq.rw   = m_RW[owner];
      sreq.addr = m_reg_address[owner];
      sreq.data = m_data_out[owner];
    end
  end

  assign s_RW          = sreq.rw;
  assign s_reg_address = sreq.addr;
  assign s_data_out    = sreq.data;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: two masters, a behavioural 4-phase slave, timeout and reset cases.
module tb_io_bus_arbiter;

  localparam int unsigned NM = 2;

  typedef struct {
    int          m;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          to;
  } item_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NM-1:0]         m_handshake_1, m_RW;
  logic [NM-1:0][7:0]    m_reg_address;
  logic [NM-1:0][31:0]   m_data_out;
  logic [NM-1:0]         m_handshake_2, m_timeout, grant;
  logic [31:0]           m_data_in, s_data_out, s_data_in;
  logic                  s_handshake_1, s_RW, s_handshake_2;
  logic [7:0]            s_reg_address;

  logic        hs1_d [NM];
  logic        rw_d  [NM];
  logic [7:0]  addr_d[NM];
  logic [31:0] wd_d  [NM];

  int n_chk = 0;
  int n_fail = 0;
  item_t sb_q[$];
  int exp_last;

  bit          slave_en = 1'b1;
  int          slave_delay = 3;
  bit          slave_fixed_en = 1'b0;
  logic [31:0] slave_fixed = '0;
  logic        obs_rw;
  logic [7:0]  obs_addr;
  logic [31:0] obs_data;
  int          hs1_run = 0;
  int          hs1_last_run = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_handshake_1[i] = hs1_d[i];
      m_RW[i]          = rw_d[i];
      m_reg_address[i] = addr_d[i];
      m_data_out[i]    = wd_d[i];
    end
  end

  io_bus_arbiter #(.NOS_MASTERS(NM), .TIMEOUT_CYCLES(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_handshake_1 (m_handshake_1),
    .m_RW          (m_RW),
    .m_reg_address (m_reg_address),
    .m_data_out    (m_data_out),
    .m_handshake_2 (m_handshake_2),
    .m_data_in     (m_data_in),
    .m_timeout     (m_timeout),
    .s_handshake_1 (s_handshake_1),
    .s_RW          (s_RW),
    .s_reg_address (s_reg_address),
    .s_data_out    (s_data_out),
    .s_handshake_2 (s_handshake_2),
    .s_data_in     (s_data_in),
    .grant         (grant)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slave_word(input logic [7:0] a);
    return slave_fixed_en ? slave_fixed : {24'h5A5A5A, a};
  endfunction

  task automatic push_item(input int m, input logic rw, input logic [7:0] a,
                           input logic [31:0] d, input bit to);
    item_t e;
    e.m = m; e.rw = rw; e.addr = a; e.wdata = d; e.to = to;
    e.rdata = to ? 32'h0 : slave_word(a);
    sb_q.push_back(e);
  endtask

  // Behavioural slave: acks slave_delay cycles after seeing a request, releases when it drops.
  initial begin
    s_handshake_2 = 1'b0;
    s_data_in     = '0;
    forever begin
      @(negedge clk);
      if (s_handshake_1 && slave_en) begin
        repeat (slave_delay) @(negedge clk);
        obs_rw        = s_RW;
        obs_addr      = s_reg_address;
        obs_data      = s_data_out;
        s_data_in     = slave_word(s_reg_address);
        s_handshake_2 = 1'b1;
        for (int n = 0; n < 1000 && s_handshake_1; n++) @(negedge clk);
        s_handshake_2 = 1'b0;
      end
    end
  end

  // Monitor: each rising completion strobe retires one scoreboard entry.
  initial begin
    logic [NM-1:0] prev;
    item_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (s_handshake_1) hs1_run++;
      else begin
        if (hs1_run != 0) hs1_last_run = hs1_run;
        hs1_run = 0;
      end
      for (int i = 0; i < NM; i++) begin
        if (m_handshake_2[i] && !prev[i]) begin
          if (sb_q.size() == 0) chk("sb_unexpected_hs2", 32'(i), 32'hFFFF_FFFF);
          else begin
            e = sb_q.pop_front();
            chk("hs2_owner", 32'(i), 32'(e.m));
            chk("hs2_vector", 32'(m_handshake_2), 32'(1 << e.m));
            chk("grant_owner", 32'(grant), 32'(1 << e.m));
            chk("timeout_flag", 32'(m_timeout), e.to ? 32'(1 << e.m) : 32'h0);
            chk("m_data_in", m_data_in, e.rdata);
            if (!e.to) begin
              chk("slave_rw", 32'(obs_rw), 32'(e.rw));
              chk("slave_addr", 32'(obs_addr), 32'(e.addr));
              chk("slave_wdata", obs_data, e.wdata);
            end
          end
        end
      end
      prev = m_handshake_2;
    end
  end

  task automatic do_xfer(input int m, input logic rw, input logic [7:0] a,
                         input logic [31:0] d, input bit lat);
    int n;
    @(negedge clk);
    rw_d[m] = rw; addr_d[m] = a; wd_d[m] = d; hs1_d[m] = 1'b1;
    if (lat) begin
      @(negedge clk);
      chk("lat_grant", 32'(grant), 32'(1 << m));
      chk("lat_shs1_early", 32'(s_handshake_1), 32'h0);
      @(negedge clk);
      chk("lat_shs1", 32'(s_handshake_1), 32'h1);
      chk("lat_saddr", 32'(s_reg_address), 32'(a));
      chk("lat_sdata", s_data_out, d);
    end
    n = 0;
    while (!m_handshake_2[m] && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("hs2_rise_wait", 32'h0, 32'h1);
    @(negedge clk);
    hs1_d[m] = 1'b0;
    n = 0;
    while (m_handshake_2[m] && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("hs2_fall_wait", 32'h0, 32'h1);
    chk("grant_released", 32'(grant), 32'h0);
    chk("timeout_cleared", 32'(m_timeout), 32'h0);
  endtask

  task automatic pair(input logic [7:0] a0, input logic [31:0] d0,
                      input logic [7:0] a1, input logic [31:0] d1);
    int first;
    first = (exp_last + 1) % 2;
    if (first == 0) begin
      push_item(0, 1'b0, a0, d0, 1'b0);
      push_item(1, 1'b0, a1, d1, 1'b0);
    end else begin
      push_item(1, 1'b0, a1, d1, 1'b0);
      push_item(0, 1'b0, a0, d0, 1'b0);
    end
    fork
      do_xfer(0, 1'b0, a0, d0, 1'b0);
      do_xfer(1, 1'b0, a1, d1, 1'b0);
    join
    exp_last = 1 - first;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < NM; i++) begin
      hs1_d[i] = 1'b0; rw_d[i] = 1'b0; addr_d[i] = '0; wd_d[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_hs2", 32'(m_handshake_2), 32'h0);
    chk("rst_timeout", 32'(m_timeout), 32'h0);
    chk("rst_shs1", 32'(s_handshake_1), 32'h0);
    chk("rst_din", m_data_in, 32'h0);
    chk("rst_saddr", 32'(s_reg_address), 32'h0);
    reset = 1'b1;
    exp_last = 1;

    // Simultaneous requests alternate starting with master 0.
    pair(8'h10, 32'h0000_1111, 8'h11, 32'h0000_2222);
    pair(8'h20, 32'h0000_3333, 8'h21, 32'h0000_4444);

    // Single write with latency checks.
    push_item(0, 1'b0, 8'h05, 32'hDEAD_BEEF, 1'b0);
    do_xfer(0, 1'b0, 8'h05, 32'hDEAD_BEEF, 1'b1);
    exp_last = 0;

    // Read by master 1 returning a fixed word.
    slave_fixed_en = 1'b1;
    slave_fixed    = 32'h1234_5678;
    slave_delay    = 2;
    push_item(1, 1'b1, 8'h40, 32'h0, 1'b0);
    do_xfer(1, 1'b1, 8'h40, 32'h0, 1'b0);
    exp_last = 1;
    slave_fixed_en = 1'b0;

    // Silent slave: abort after the timeout window.
    slave_en = 1'b0;
    push_item(0, 1'b0, 8'h77, 32'hCAFE_F00D, 1'b1);
    do_xfer(0, 1'b0, 8'h77, 32'hCAFE_F00D, 1'b0);
    chk("timeout_len", 32'(hs1_last_run), 32'd255);
    exp_last = 0;
    slave_en = 1'b1;

    // Reset while master 1 sits in ACK; arbiter must pick master 0 first afterwards.
    push_item(1, 1'b0, 8'h33, 32'h0BAD_CAFE, 1'b0);
    @(negedge clk);
    rw_d[1] = 1'b0; addr_d[1] = 8'h33; wd_d[1] = 32'h0BAD_CAFE; hs1_d[1] = 1'b1;
    n = 0;
    while (!m_handshake_2[1] && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("ack_state_wait", 32'h0, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_hs2", 32'(m_handshake_2), 32'h0);
    chk("arst_shs1", 32'(s_handshake_1), 32'h0);
    chk("arst_din", m_data_in, 32'h0);
    chk("arst_saddr", 32'(s_reg_address), 32'h0);
    chk("arst_sdata", s_data_out, 32'h0);
    hs1_d[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_last = 1;
    repeat (3) @(negedge clk);
    pair(8'h50, 32'h5555_0000, 8'h51, 32'h6666_0000);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
